dbg_fetch_arbiter: RTL and testbench
====================================

Name: dbg_fetch_arbiter

Overview:
- Sequences board-side debug reads of the data memory or register file in the multicycle MIPS while sharing those read ports with the CPU.
- Waits for the CPU to reach an instruction boundary, stalls it, and performs one read with fixed latency.
- Captures the 32-bit word and releases the CPU. Presents one selectable byte of the word as two 4-bit nibbles for the seven-segment drivers.

Parameters:
- RD_LAT, 1, read latency in cycles from the read-enable pulse to valid read data (1..7).
- SAFE_TIMEOUT, 255, maximum cycles to wait for cpu_safe before aborting (1..255).
- REFRESH_CYCLES, 1000000, re-read period used only with the optional feature.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dbg_req  in  1  one-cycle pulse from the debounced button; starts a read.
- dbg_sel  in  1  read target: 1 = register file, 0 = data memory. Sampled with dbg_req.
- dbg_addr  in  15  switch address. Sampled with dbg_req.
- byte_next  in  1  one-cycle pulse; advances the displayed byte.
- cpu_safe  in  1  high while the CPU is at an instruction boundary (fetch state).
- mem_rdata  in  32  data memory read data.
- reg_rdata  in  32  register file read data.
- cpu_stall  out  1  freezes the CPU state register and PC.
- mem_en  out  1  data memory debug read enable.
- reg_en  out  1  register file debug read enable.
- dbg_addr_out  out  32  zero-extended sampled address: {17'd0, addr}. The register file uses bits [4:0].
- dbg_busy  out  1  high in any state other than IDLE and HOLD.
- dbg_valid  out  1  captured word is valid.
- timeout_err  out  1  sticky; last request aborted because of the timeout.
- seg_lo  out  4  low nibble of the selected byte.
- seg_hi  out  4  high nibble of the selected byte.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE. All outputs 0. Captured word = 0. Byte index = 0. Counters = 0.
  - If reset is asserted mid-operation, cpu_stall drops immediately, with no completion.
- States: IDLE, WAIT_SAFE, STALL, ACCESS, CAPTURE, HOLD.
- IDLE:
  - On dbg_req, latch dbg_sel and dbg_addr, clear timeout_err, go to WAIT_SAFE.
- WAIT_SAFE:
  - If cpu_safe is high, go to STALL.
  - Otherwise increment the wait counter. When it reaches SAFE_TIMEOUT, set timeout_err and go to IDLE.
- STALL:
  - cpu_stall = 1 for one cycle so the CPU freezes, then go to ACCESS.
- ACCESS:
  - cpu_stall stays 1. mem_en or reg_en (chosen by the latched sel) is high only in the first ACCESS cycle.
  - The state lasts exactly RD_LAT cycles, then goes to CAPTURE.
- CAPTURE:
  - cpu_stall = 1. Register the selected rdata into the captured word.
  - Set dbg_valid = 1, reset the byte index to 0, go to HOLD.
- Cycle count from dbg_req (cpu_safe already high): cpu_stall asserts on cycle 2 and stays high for RD_LAT + 2 cycles. dbg_valid rises on the cycle after CAPTURE.
- HOLD:
  - cpu_stall = 0, so the CPU runs.
  - A new dbg_req re-latches sel/addr, drops dbg_valid, and goes to WAIT_SAFE.
- Request filtering: dbg_req in any state other than IDLE or HOLD is ignored.
- Byte display:
  - byte_next increments the 2-bit byte index; 3 wraps to 0.
  - byte_next is ignored unless dbg_valid = 1.
  - seg_lo = word[8*i+3 : 8*i], seg_hi = word[8*i+7 : 8*i+4]. Both are registered, so they update one cycle after a byte_next or capture.
  - Both read 0 while dbg_valid = 0.
- Simultaneous events:
  - dbg_req and byte_next in the same HOLD cycle: dbg_req wins; byte_next is dropped.
  - cpu_safe falling during STALL or ACCESS has no effect, because the CPU is already stalled.
- mem_en and reg_en are never high together.

Optional Feature:
- Macro: DBG_AUTO_REFRESH_EN.
- Defined:
  - HOLD runs a refresh counter. After REFRESH_CYCLES it re-enters WAIT_SAFE with the same sel/addr.
  - dbg_valid stays 1 and the byte index is kept, so the display tracks live memory.
  - A timeout during a refresh sets timeout_err, returns to HOLD, and keeps the old word.
- Undefined: HOLD waits indefinitely. No refresh counter is synthesized.

Test Plan:
- Data read: cpu_safe = 1, dbg_sel = 0, dbg_addr = 15'h0010, mem_rdata = 32'hDEADBEEF, RD_LAT = 1.
  -> mem_en is one pulse, dbg_addr_out = 32'h00000010, cpu_stall is high for 3 cycles, dbg_valid = 1, seg_hi/seg_lo = E/F.
- Register read plus byte walk: dbg_sel = 1, addr = 5, reg_rdata = 32'h12345678; then 4 byte_next pulses.
  -> reg_en pulses, mem_en stays 0. Nibble pairs (hi, lo) = 7/8, 5/6, 3/4, 1/2, then wraps to 7/8.
- Timeout: cpu_safe held 0, SAFE_TIMEOUT = 4, dbg_req.
  -> cpu_stall never asserts, timeout_err = 1 after 4 wait cycles, state returns to IDLE, dbg_valid = 0.
- Late safe plus ignored request: cpu_safe rises 3 cycles after dbg_req; a second dbg_req arrives during ACCESS.
  -> a single read completes, and the second request has no effect.
- Reset mid-ACCESS: assert rst_n = 0 while cpu_stall = 1.
  -> cpu_stall, mem_en, dbg_valid, seg_lo and seg_hi all go to 0 asynchronously; state is IDLE after release.
- DBG_AUTO_REFRESH_EN, REFRESH_CYCLES = 20: mem_rdata changes from 32'h000000AA to 32'h000000BB while in HOLD.
  -> seg_hi/seg_lo change from A/A to B/B about 20 cycles later, and dbg_valid never drops.

Source files
------------

// File: rtl/dbg_fetch_arbiter.sv
// Debug read sequencer for the multicycle MIPS: waits for an instruction boundary, stalls the CPU,
// reads one word with fixed latency and shows a selectable byte as two nibbles. Optional: DBG_AUTO_REFRESH_EN.
module dbg_fetch_arbiter #(
  parameter int RD_LAT         = 1,
  parameter int SAFE_TIMEOUT   = 255,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbg_req,
  input  logic        dbg_sel,
  input  logic [14:0] dbg_addr,
  input  logic        byte_next,
  input  logic        cpu_safe,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] reg_rdata,
  output logic        cpu_stall,
  output logic        mem_en,
  output logic        reg_en,
  output logic [31:0] dbg_addr_out,
  output logic        dbg_busy,
  output logic        dbg_valid,
  output logic        timeout_err,
  output logic [3:0]  seg_lo,
  output logic [3:0]  seg_hi
);

  if (RD_LAT < 1 || RD_LAT > 7 || SAFE_TIMEOUT < 1 || SAFE_TIMEOUT > 255 || REFRESH_CYCLES < 1)
  begin : g_param_check
    $error("dbg_fetch_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SAFE,
    S_STALL,
    S_ACCESS,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wait_q, wait_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [3:0]  seg_lo_q, seg_hi_q;
  logic [7:0]  byte_d;

`ifdef DBG_AUTO_REFRESH_EN
  localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
  logic            refresh_q, refresh_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
`endif

  // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    lat_d   = lat_q;
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef DBG_AUTO_REFRESH_EN
    refresh_d = refresh_q;
    rcnt_d    = '0;
`endif

    // A request arriving in HOLD takes priority over a byte step in the same cycle.
    if (byte_next && valid_q && !(state_q == S_HOLD && dbg_req))
      idx_d = idx_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (dbg_req) begin
          sel_d   = dbg_sel;
          addr_d  = dbg_addr;
          err_d   = 1'b0;
          wait_d  = '0;
          state_d = S_WAIT_SAFE;
        end
      end
      S_WAIT_SAFE: begin
        if (cpu_safe) begin
          state_d = S_STALL;
        end else if (wait_q == 8'(SAFE_TIMEOUT - 1)) begin
          err_d = 1'b1;
`ifdef DBG_AUTO_REFRESH_EN
          // A failed refresh falls back to the word already on display.
          state_d   = refresh_q ? S_HOLD : S_IDLE;
          refresh_d = 1'b0;
`else
          state_d = S_IDLE;
`endif
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_STALL: begin
        lat_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (lat_q == 3'(RD_LAT - 1)) state_d = S_CAPTURE;
        else                         lat_d   = lat_q + 3'd1;
      end
      S_CAPTURE: begin
        word_d  = sel_q ? reg_rdata : mem_rdata;
        valid_d = 1'b1;
`ifdef DBG_AUTO_REFRESH_EN
        if (!refresh_q) idx_d = '0;
        refresh_d = 1'b0;
`else
        idx_d = '0;
`endif
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (dbg_req) begin
          sel_d   = dbg_sel;
          addr_d  = dbg_addr;
          err_d   = 1'b0;
          valid_d = 1'b0;
          wait_d  = '0;
          state_d = S_WAIT_SAFE;
        end
`ifdef DBG_AUTO_REFRESH_EN
        else if (rcnt_q == RC_W'(REFRESH_CYCLES - 1)) begin
          refresh_d = 1'b1;
          wait_d    = '0;
          state_d   = S_WAIT_SAFE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Display registers load from the next-state word/index so they move together with dbg_valid.
    byte_d = word_d[{idx_d, 3'b000} +: 8];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      wait_q   <= '0;
      lat_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      seg_lo_q <= '0;
      seg_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wait_q   <= wait_d;
      lat_q    <= lat_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seg_lo_q <= valid_d ? byte_d[3:0] : 4'd0;
      seg_hi_q <= valid_d ? byte_d[7:4] : 4'd0;
    end
  end

`ifdef DBG_AUTO_REFRESH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      refresh_q <= refresh_d;
      rcnt_q    <= rcnt_d;
    end
  end
`endif

  // Outputs decode straight from registers, so reset clears them without waiting for a clock.
  assign cpu_stall    = (state_q == S_STALL) || (state_q == S_ACCESS) || (state_q == S_CAPTURE);
  assign mem_en       = (state_q == S_ACCESS) && (lat_q == 3'd0) && !sel_q;
  assign reg_en       = (state_q == S_ACCESS) && (lat_q == 3'd0) && sel_q;
  assign dbg_addr_out = {17'd0, addr_q};
  assign dbg_busy     = (state_q != S_IDLE) && (state_q != S_HOLD);
  assign dbg_valid    = valid_q;
  assign timeout_err  = err_q;
  assign seg_lo       = seg_lo_q;
  assign seg_hi       = seg_hi_q;

endmodule

// File: tb/tb_dbg_fetch_arbiter.sv
// Directed bench for dbg_fetch_arbiter: read sequencing, byte walk, timeout, filtering and async reset.
// With DBG_AUTO_REFRESH_EN defined, a second instance checks the periodic re-read.
module tb_dbg_fetch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, dbg_req, dbg_sel, byte_next, cpu_safe;
  logic [14:0] dbg_addr;
  logic [31:0] mem_rdata, reg_rdata, mem_word, reg_word;
  logic        cpu_stall, mem_en, reg_en, dbg_busy, dbg_valid, timeout_err;
  logic [31:0] dbg_addr_out;
  logic [3:0]  seg_lo, seg_hi;

  int n_cmp = 0;
  int n_bad = 0;
  int n_stall = 0, n_mem_en = 0, n_reg_en = 0, n_both = 0;

  dbg_fetch_arbiter #(.RD_LAT(1), .SAFE_TIMEOUT(4), .REFRESH_CYCLES(5000)) u_dut (
    .clk(clk), .rst_n(rst_n), .dbg_req(dbg_req), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr),
    .byte_next(byte_next), .cpu_safe(cpu_safe), .mem_rdata(mem_rdata), .reg_rdata(reg_rdata),
    .cpu_stall(cpu_stall), .mem_en(mem_en), .reg_en(reg_en), .dbg_addr_out(dbg_addr_out),
    .dbg_busy(dbg_busy), .dbg_valid(dbg_valid), .timeout_err(timeout_err),
    .seg_lo(seg_lo), .seg_hi(seg_hi)
  );

  // One-cycle-latency memories: correct data appears only the cycle after the enable.
  always @(posedge clk) begin
    mem_rdata <= mem_en ? mem_word : 32'h0BAD_F00D;
    reg_rdata <= reg_en ? reg_word : 32'h0BAD_F00D;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_stall)       n_stall++;
      if (mem_en)          n_mem_en++;
      if (reg_en)          n_reg_en++;
      if (mem_en && reg_en) n_both++;
    end
  end

`ifdef DBG_AUTO_REFRESH_EN
  logic [31:0] rf_mem_rdata, rf_addr_out;
  logic        rf_stall, rf_mem_en, rf_reg_en, rf_busy, rf_valid, rf_err;
  logic [3:0]  rf_seg_lo, rf_seg_hi;

  dbg_fetch_arbiter #(.RD_LAT(1), .SAFE_TIMEOUT(4), .REFRESH_CYCLES(20)) u_dut_rf (
    .clk(clk), .rst_n(rst_n), .dbg_req(dbg_req), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr),
    .byte_next(byte_next), .cpu_safe(cpu_safe), .mem_rdata(rf_mem_rdata), .reg_rdata(32'h0),
    .cpu_stall(rf_stall), .mem_en(rf_mem_en), .reg_en(rf_reg_en), .dbg_addr_out(rf_addr_out),
    .dbg_busy(rf_busy), .dbg_valid(rf_valid), .timeout_err(rf_err),
    .seg_lo(rf_seg_lo), .seg_hi(rf_seg_hi)
  );

  always @(posedge clk) rf_mem_rdata <= rf_mem_en ? mem_word : 32'h0BAD_F00D;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (dbg_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(dbg_valid), 32'd1);
  endtask

  initial begin
    int s0, m0, r0;
    logic [3:0] exp_hi [4];
    logic [3:0] exp_lo [4];
    exp_hi = '{4'h5, 4'h3, 4'h1, 4'h7};
    exp_lo = '{4'h6, 4'h4, 4'h2, 4'h8};

    rst_n = 1'b0; dbg_req = 1'b0; dbg_sel = 1'b0; dbg_addr = '0; byte_next = 1'b0;
    cpu_safe = 1'b0; mem_word = '0; reg_word = '0;
    repeat (2) tick();
    check("rst stall", 32'(cpu_stall), 0);
    check("rst en", {30'd0, mem_en, reg_en}, 0);
    check("rst addr", dbg_addr_out, 0);
    check("rst busy/valid/err", {29'd0, dbg_busy, dbg_valid, timeout_err}, 0);
    check("rst seg", {24'd0, seg_hi, seg_lo}, 0);
    rst_n = 1'b1;
    tick();

    // Data read, cpu_safe already high: stall on cycles 2..4, valid on cycle 5.
    cpu_safe = 1'b1; mem_word = 32'hDEAD_BEEF;
    dbg_sel = 1'b0; dbg_addr = 15'h0010; dbg_req = 1'b1;
    s0 = n_stall; m0 = n_mem_en; r0 = n_reg_en;
    tick(); dbg_req = 1'b0;
    check("t1 busy c1", 32'(dbg_busy), 1);
    check("t1 stall c1", 32'(cpu_stall), 0);
    tick();
    check("t1 stall c2", 32'(cpu_stall), 1);
    tick();
    check("t1 mem_en c3", 32'(mem_en), 1);
    tick();
    check("t1 stall c4", 32'(cpu_stall), 1);
    check("t1 valid c4", 32'(dbg_valid), 0);
    tick();
    check("t1 stall c5", 32'(cpu_stall), 0);
    check("t1 valid c5", 32'(dbg_valid), 1);
    check("t1 busy c5", 32'(dbg_busy), 0);
    check("t1 seg", {24'd0, seg_hi, seg_lo}, 32'hEF);
    check("t1 addr", dbg_addr_out, 32'h0000_0010);
    check("t1 stall cycles", 32'(n_stall - s0), 3);
    check("t1 mem_en pulses", 32'(n_mem_en - m0), 1);
    check("t1 reg_en pulses", 32'(n_reg_en - r0), 0);

    // Register read from HOLD, then walk all four bytes and wrap.
    dbg_sel = 1'b1; dbg_addr = 15'd5; reg_word = 32'h1234_5678; dbg_req = 1'b1;
    m0 = n_mem_en; r0 = n_reg_en;
    tick(); dbg_req = 1'b0;
    check("t2 valid drop", 32'(dbg_valid), 0);
    check("t2 seg cleared", {24'd0, seg_hi, seg_lo}, 0);
    wait_valid("t2 valid", 10);
    check("t2 seg b0", {24'd0, seg_hi, seg_lo}, 32'h78);
    check("t2 addr", dbg_addr_out, 32'h0000_0005);
    check("t2 reg_en pulses", 32'(n_reg_en - r0), 1);
    check("t2 mem_en pulses", 32'(n_mem_en - m0), 0);
    for (int i = 0; i < 4; i++) begin
      byte_next = 1'b1;
      tick(); byte_next = 1'b0;
      check($sformatf("t2 byte step %0d", i), {24'd0, seg_hi, seg_lo}, {24'd0, exp_hi[i], exp_lo[i]});
    end

    // Timeout: four wait cycles with cpu_safe low, then back to IDLE.
    cpu_safe = 1'b0; dbg_sel = 1'b0; dbg_addr = 15'h0022; dbg_req = 1'b1;
    s0 = n_stall;
    tick(); dbg_req = 1'b0;
    check("t3 busy", 32'(dbg_busy), 1);
    check("t3 valid drop", 32'(dbg_valid), 0);
    repeat (3) tick();
    check("t3 err before limit", 32'(timeout_err), 0);
    check("t3 busy before limit", 32'(dbg_busy), 1);
    tick();
    check("t3 err at limit", 32'(timeout_err), 1);
    check("t3 idle", 32'(dbg_busy), 0);
    check("t3 valid", 32'(dbg_valid), 0);
    check("t3 no stall", 32'(n_stall - s0), 0);

    // Late cpu_safe, plus a request during ACCESS that must be ignored.
    mem_word = 32'hCAFE_0042; dbg_sel = 1'b0; dbg_addr = 15'h7FFF; dbg_req = 1'b1;
    s0 = n_stall; m0 = n_mem_en; r0 = n_reg_en;
    tick(); dbg_req = 1'b0;
    check("t4 err cleared", 32'(timeout_err), 0);
    tick();
    tick(); cpu_safe = 1'b1;
    tick();
    check("t4 stall", 32'(cpu_stall), 1);
    tick();
    check("t4 mem_en", 32'(mem_en), 1);
    dbg_req = 1'b1; dbg_sel = 1'b1; dbg_addr = 15'd3;
    tick(); dbg_req = 1'b0; dbg_sel = 1'b0;
    tick();
    check("t4 valid", 32'(dbg_valid), 1);
    check("t4 seg", {24'd0, seg_hi, seg_lo}, 32'h42);
    check("t4 addr", dbg_addr_out, 32'h0000_7FFF);
    repeat (4) tick();
    check("t4 stays hold", {30'd0, dbg_busy, dbg_valid}, 32'b01);
    check("t4 stall cycles", 32'(n_stall - s0), 3);
    check("t4 mem_en pulses", 32'(n_mem_en - m0), 1);
    check("t4 reg_en pulses", 32'(n_reg_en - r0), 0);

    // Request and byte step together in HOLD, then reset in the middle of ACCESS.
    mem_word = 32'h1111_1111; dbg_addr = 15'h0040; dbg_req = 1'b1; byte_next = 1'b1;
    tick(); dbg_req = 1'b0; byte_next = 1'b0;
    check("t5 req wins valid", 32'(dbg_valid), 0);
    check("t5 req wins seg", {24'd0, seg_hi, seg_lo}, 0);
    tick();
    tick();
    check("t5 in access", {30'd0, cpu_stall, mem_en}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async stall", 32'(cpu_stall), 0);
    check("t5 async mem_en", 32'(mem_en), 0);
    check("t5 async busy", 32'(dbg_busy), 0);
    tick(); rst_n = 1'b1;
    tick();
    check("t5 idle after rst", {29'd0, dbg_busy, dbg_valid, cpu_stall}, 0);

    // Reset while a valid word is displayed.
    mem_word = 32'h0000_00A5; dbg_addr = 15'd1; dbg_req = 1'b1;
    tick(); dbg_req = 1'b0;
    wait_valid("t6 valid", 10);
    check("t6 seg", {24'd0, seg_hi, seg_lo}, 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async valid", 32'(dbg_valid), 0);
    check("t6 async seg", {24'd0, seg_hi, seg_lo}, 0);
    tick(); rst_n = 1'b1;
    tick();

`ifdef DBG_AUTO_REFRESH_EN
    begin
      int n = 0;
      int drops = 0;
      mem_word = 32'h0000_00AA; dbg_sel = 1'b0; dbg_addr = 15'd2; dbg_req = 1'b1;
      tick(); dbg_req = 1'b0;
      while (rf_valid !== 1'b1 && n < 10) begin tick(); n++; end
      check("rf valid", 32'(rf_valid), 1);
      check("rf seg AA", {24'd0, rf_seg_hi, rf_seg_lo}, 32'hAA);
      mem_word = 32'h0000_00BB;
      n = 0;
      while (rf_seg_lo !== 4'hB && n < 60) begin
        tick();
        if (rf_valid !== 1'b1) drops++;
        n++;
      end
      check("rf seg BB", {24'd0, rf_seg_hi, rf_seg_lo}, 32'hBB);
      check("rf valid drops", 32'(drops), 0);
    end
`endif

    check("en never both", 32'(n_both), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
